// File: rtl/fsm_pkg.sv
// Shared recognizer definitions: state encoding, Moore output mask and the
// next-state / output functions applied to whichever channel context is granted.
package fsm_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  // Bit k set means state code k drives z=1 (S3 and S4 only).
  localparam logic [7:0] Z_STATES = 8'b0001_1000;

  function automatic logic [ST_W-1:0] fsm_next(input logic [ST_W-1:0] s, input logic x);
    logic [ST_W-1:0] n;
    n = S0;
    case (s)
      S0:      n = x ? S1 : S0;
      S1:      n = x ? S4 : S1;
      S2:      n = x ? S1 : S2;
      S3:      n = x ? S2 : S1;
      S4:      n = x ? S4 : S3;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic fsm_z(input logic [ST_W-1:0] s);
    return Z_STATES[s];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible channel after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [CH_W-1:0] rr_ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);

  logic [CH_W-1:0] cand;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= int'(N_CH); k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % int'(N_CH));
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fsm_ctx_sched.sv
// Time-shares one recognizer between N_CH bit streams: per-channel saved state,
// round-robin grant, and a single backpressured result register.
module fsm_ctx_sched
  import fsm_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned CH_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_CH-1:0]  req_valid,
  input  logic [N_CH-1:0]  req_x,
  output logic [N_CH-1:0]  req_ready,
  input  logic [N_CH-1:0]  ch_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_z,
  output logic [ST_W-1:0]  out_state,
  output logic [CNT_W-1:0] hit_count
);

  logic [ST_W-1:0]  ctx   [N_CH];
  logic [ST_W-1:0]  ctx_d [N_CH];
  logic [CH_W-1:0]  rr_ptr, rr_ptr_d;
  logic             out_valid_d, out_z_d;
  logic [CH_W-1:0]  out_ch_d;
  logic [ST_W-1:0]  out_state_d;
  logic [CNT_W-1:0] hit_count_d;

  logic             stall, accept;
  logic [N_CH-1:0]  eligible, grant;
  logic [CH_W-1:0]  gidx;
  logic [ST_W-1:0]  cur_st, nxt_st;

  // A pending unconsumed result blocks all new grants; no grants during reset.
  assign stall    = out_valid & ~out_ready;
  assign eligible = req_valid & ~ch_clear & {N_CH{~stall & resetn}};

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign cur_st    = ctx[gidx];
  assign nxt_st    = fsm_next(cur_st, req_x[gidx]);

  always_comb begin
    ctx_d       = ctx;
    rr_ptr_d    = rr_ptr;
    out_valid_d = out_valid;
    out_ch_d    = out_ch;
    out_z_d     = out_z;
    out_state_d = out_state;
    hit_count_d = hit_count;

    for (int i = 0; i < int'(N_CH); i++) begin
      if (ch_clear[i]) begin
        ctx_d[i] = S0;
      end else if (grant[i]) begin
        ctx_d[i] = nxt_st;
      end
    end

    if (accept) begin
      rr_ptr_d    = gidx;
      out_valid_d = 1'b1;
      out_ch_d    = gidx;
      out_z_d     = fsm_z(cur_st);
      out_state_d = nxt_st;
    end else if (!stall) begin
      out_valid_d = 1'b0;
    end

    // Counts delivered hits; sticks at all-ones.
    if (out_valid && out_ready && out_z && (hit_count != {CNT_W{1'b1}})) begin
      hit_count_d = hit_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        ctx[i] <= S0;
      end
      rr_ptr    <= CH_W'(N_CH - 1);
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_z     <= 1'b0;
      out_state <= '0;
      hit_count <= '0;
    end else begin
      ctx       <= ctx_d;
      rr_ptr    <= rr_ptr_d;
      out_valid <= out_valid_d;
      out_ch    <= out_ch_d;
      out_z     <= out_z_d;
      out_state <= out_state_d;
      hit_count <= hit_count_d;
    end
  end

endmodule

// File: tb/tb_fsm_ctx_sched.sv
// Scoreboard bench for fsm_ctx_sched: directed stimulus pushes expected results,
// a negedge monitor pops and compares each delivered result.
module tb_fsm_ctx_sched;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CH_W  = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N_CH-1:0]  req_valid, req_x, req_ready, ch_clear;
  logic             out_valid, out_ready, out_z;
  logic [CH_W-1:0]  out_ch;
  logic [2:0]       out_state;
  logic [CNT_W-1:0] hit_count;

  typedef struct packed {
    logic [1:0] ch;
    logic       z;
    logic [2:0] st;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fsm_ctx_sched #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .ch_clear  (ch_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_z     (out_z),
    .out_state (out_state),
    .hit_count (hit_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: each negedge with valid&ready is one delivery at the next edge.
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: unexpected ch=%0d z=%0d st=%0d, expected none", out_ch, out_z, out_state);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result{ch,z,st}", 32'({out_ch, out_z, out_state}), 32'(mon_e));
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1; grant checked at negedge.
  task automatic step(input logic [3:0] v, input logic [3:0] x, input logic [3:0] clr,
                      input logic rdy, input logic [3:0] g, input logic push,
                      input logic [1:0] ch, input logic z, input logic [2:0] st);
    req_valid = v;
    req_x     = x;
    ch_clear  = clr;
    out_ready = rdy;
    if (push) exp_q.push_back({ch, z, st});
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(g));
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [3:0] v, input logic [3:0] x, input logic [3:0] clr,
                     input int ch, input logic z, input logic [2:0] st);
    step(v, x, clr, 1'b1, 4'(1 << ch), 1'b1, 2'(ch), z, st);
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0);
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 4'hF;
    req_x     = 4'h0;
    ch_clear  = 4'h0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst hit_count", 32'(hit_count), 32'h0);
    chk("rst out_state", 32'(out_state), 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // ch0 alone, x = 1,1,0,1
    acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 3'd1);
    acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 3'd4);
    acc(4'b0001, 4'b0000, 4'b0000, 0, 1'b1, 3'd3);
    acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b1, 3'd2);
    idle();
    idle();
    chk("hit after ch0 seq", 32'(hit_count), 32'd2);

    // All channels valid: round-robin from ch1; x: ch1,ch2=1, ch0,ch3=0
    acc(4'b1111, 4'b0110, 4'b0000, 1, 1'b0, 3'd1);
    acc(4'b1111, 4'b0110, 4'b0000, 2, 1'b0, 3'd1);
    acc(4'b1111, 4'b0110, 4'b0000, 3, 1'b0, 3'd0);
    acc(4'b1111, 4'b0110, 4'b0000, 0, 1'b0, 3'd2);
    acc(4'b1111, 4'b0110, 4'b0000, 1, 1'b0, 3'd4);
    acc(4'b1111, 4'b0110, 4'b0000, 2, 1'b0, 3'd4);
    acc(4'b1111, 4'b0110, 4'b0000, 3, 1'b0, 3'd0);
    acc(4'b1111, 4'b0110, 4'b0000, 0, 1'b0, 3'd2);

    // Backpressure: ch1 S4 result held for 3 stalled cycles
    acc(4'b1111, 4'b0000, 4'b0000, 1, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 3'd0);
      chk("stall out_ch", 32'(out_ch), 32'd1);
      chk("stall out_z", 32'(out_z), 32'd1);
      chk("stall out_valid", 32'(out_valid), 32'd1);
    end
    acc(4'b1111, 4'b0000, 4'b0000, 2, 1'b1, 3'd3);
    acc(4'b1111, 4'b0000, 4'b0000, 3, 1'b0, 3'd0);
    acc(4'b1111, 4'b0000, 4'b0000, 0, 1'b0, 3'd2);
    chk("hit after stall", 32'(hit_count), 32'd4);

    // Clear vs request: drive ch1 S3 -> S1 -> S4, then clear it while requesting
    acc(4'b0010, 4'b0000, 4'b0000, 1, 1'b1, 3'd1);
    acc(4'b0010, 4'b0010, 4'b0000, 1, 1'b0, 3'd4);
    acc(4'b1111, 4'b0000, 4'b0010, 2, 1'b1, 3'd1);
    acc(4'b1111, 4'b0000, 4'b0000, 3, 1'b0, 3'd0);
    acc(4'b1111, 4'b0000, 4'b0000, 0, 1'b0, 3'd2);
    acc(4'b1111, 4'b0000, 4'b0000, 1, 1'b0, 3'd0);

    // Saturation: ch0 S2 -> S1 -> S4, then 20 hits on top of 6
    acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 3'd1);
    acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 3'd4);
    for (int i = 0; i < 20; i++) acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b1, 3'd4);
    idle();
    idle();
    chk("hit saturated", 32'(hit_count), 32'd15);

    // Reset with a result pending: it is discarded
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 3'd4);
    step(4'b1111, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 3'd0);
    resetn = 1'b0;
    exp_q.delete();
    step(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 3'd0);
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst hit_count", 32'(hit_count), 32'h0);
    step(4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 3'd0);
    resetn = 1'b1;
    acc(4'b0001, 4'b0001, 4'b0000, 0, 1'b0, 3'd1);
    idle();
    idle();
    chk("post-rst hit_count", 32'(hit_count), 32'd0);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
